// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the K=4, rate-1/2 Viterbi decoder (G1=1111, G0=1101).
package viterbi_pkg;

    localparam int NUM_STATES = 8;
    localparam int K          = 4;
    localparam logic [K-1:0] G1 = 4'b1111;
    localparam logic [K-1:0] G0 = 4'b1101;

    localparam int PM_WIDTH = 8;
    typedef logic [PM_WIDTH-1:0] pm_t;

    // Codeword {c1,c0} emitted when input u is shifted into encoder state 'state'.
    function automatic logic [1:0] exp_code(input logic [2:0] state, input logic u);
        logic [K-1:0] r;
        r = {u, state};
        return {^(r & G1), ^(r & G0)};
    endfunction

endpackage

// File: rtl/acs_unit.sv
// One add-compare-select cell: extends both predecessor metrics and keeps the smaller.
module acs_unit #(
    parameter int PM_W = 8
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W-1:0] new_pm,
    output logic            dec
);

    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    assign cand0 = pm0 + {{(PM_W-2){1'b0}}, bm0};
    assign cand1 = pm1 + {{(PM_W-2){1'b0}}, bm1};

    // Strict compare so a tie resolves to the lower-numbered predecessor.
    assign dec    = (cand1 < cand0);
    assign new_pm = dec ? cand1 : cand0;

endmodule

// File: rtl/acs_path_metric.sv
// ACS stage: eight registered path metrics, survivor decisions per next-state,
// and the best state with its normalized metric, one trellis step per valid.
module acs_path_metric
    import viterbi_pkg::*;
#(
    parameter int PM_W    = 8,
    parameter int INIT_PM = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sync_clr,
    input  logic            in_valid,
    input  logic [7:0]      bm,
    output logic [7:0]      dec_bits,
    output logic            dec_valid,
    output logic [2:0]      best_state,
    output logic [PM_W-1:0] best_pm
);

    logic [PM_W-1:0]       pm      [NUM_STATES];
    logic [PM_W-1:0]       new_pm  [NUM_STATES];
    logic [PM_W-1:0]       norm_pm [NUM_STATES];
    logic [NUM_STATES-1:0] dec;
    logic [PM_W-1:0]       min_pm;
    logic [PM_W-1:0]       min_norm;
    logic [2:0]            min_idx;
    logic                  norm;

    // Predecessors of ns are {ns[1:0],b}; the input bit on both branches is ns[2].
    for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
        localparam logic [2:0] NS = 3'(g);
        localparam logic [2:0] P0 = {NS[1:0], 1'b0};
        localparam logic [2:0] P1 = {NS[1:0], 1'b1};
        localparam logic [1:0] C0 = exp_code(P0, NS[2]);
        localparam logic [1:0] C1 = exp_code(P1, NS[2]);

        acs_unit #(.PM_W(PM_W)) u_acs (
            .pm0    (pm[P0]),
            .pm1    (pm[P1]),
            .bm0    (bm[2*int'(C0) +: 2]),
            .bm1    (bm[2*int'(C1) +: 2]),
            .new_pm (new_pm[g]),
            .dec    (dec[g])
        );
    end

    // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        min_pm  = new_pm[0];
        min_idx = '0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (new_pm[i] < min_pm) begin
                min_pm  = new_pm[i];
                min_idx = 3'(i);
            end
        end
        // All metrics share the MSB once the minimum reaches half range; dropping it subtracts 2**(PM_W-1).
        norm     = min_pm[PM_W-1];
        min_norm = norm ? {1'b0, min_pm[PM_W-2:0]} : min_pm;
        for (int i = 0; i < NUM_STATES; i++) begin
            norm_pm[i] = norm ? {1'b0, new_pm[i][PM_W-2:0]} : new_pm[i];
        end
    end

    // NOTE: the metric array is reset explicitly; its start values define trellis step 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm[i] <= (i == 0) ? '0 : PM_W'(INIT_PM);
            end
            dec_bits   <= '0;
            dec_valid  <= 1'b0;
            best_state <= '0;
            best_pm    <= '0;
        end else if (sync_clr) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm[i] <= (i == 0) ? '0 : PM_W'(INIT_PM);
            end
            dec_bits   <= '0;
            dec_valid  <= 1'b0;
            best_state <= '0;
            best_pm    <= '0;
        end else if (in_valid) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm[i] <= norm_pm[i];
            end
            dec_bits   <= dec;
            dec_valid  <= 1'b1;
            best_state <= min_idx;
            best_pm    <= min_norm;
        end else begin
            dec_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acs_path_metric.sv
// Self-checking bench for acs_path_metric: directed trellis scenarios plus random
// branch metrics, compared against a forward-transition reference model.
module tb_acs_path_metric;

    localparam int PM_W    = 8;
    localparam int INIT_PM = 16;
    localparam int HALF    = 1 << (PM_W - 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sync_clr;
    logic            in_valid;
    logic [7:0]      bm;
    logic [7:0]      dec_bits;
    logic            dec_valid;
    logic [2:0]      best_state;
    logic [PM_W-1:0] best_pm;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_pm [8];
    logic [7:0] m_dec;
    int         m_bs;
    int         m_bp;
    logic       m_valid;

    acs_path_metric #(.PM_W(PM_W), .INIT_PM(INIT_PM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_clr   (sync_clr),
        .in_valid   (in_valid),
        .bm         (bm),
        .dec_bits   (dec_bits),
        .dec_valid  (dec_valid),
        .best_state (best_state),
        .best_pm    (best_pm)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int parity(input int v);
        return $countones(v) & 1;
    endfunction

    // Codeword produced when input u enters encoder state s, as a 2-bit integer {c1,c0}.
    function automatic int encode(input int s, input int u);
        int r;
        r = u * 8 + s;
        return parity(r & 15) * 2 + parity(r & 13);
    endfunction

    function automatic logic [7:0] bm_for(input int rx);
        logic [7:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) begin
            v = v | (8'($countones(rx ^ c)) << (2 * c));
        end
        return v;
    endfunction

    task automatic model_reset();
        m_pm[0] = 0;
        for (int i = 1; i < 8; i++) m_pm[i] = INIT_PM;
        m_dec   = '0;
        m_bs    = 0;
        m_bp    = 0;
        m_valid = 1'b0;
    endtask

    // Walks every (state, input) transition forward and keeps the best arrival per state.
    task automatic model_step(input logic v, input logic [7:0] b, input logic clr);
        int nxt [8];
        int mn;
        int ns;
        int d;
        int cand;
        if (clr) begin
            model_reset();
            return;
        end
        if (!v) begin
            m_valid = 1'b0;
            return;
        end
        for (int i = 0; i < 8; i++) nxt[i] = -1;
        for (int s = 0; s < 8; s++) begin
            for (int u = 0; u < 2; u++) begin
                ns   = u * 4 + s / 2;
                d    = (int'(b) >> (2 * encode(s, u))) & 3;
                cand = m_pm[s] + d;
                if (nxt[ns] < 0 || cand < nxt[ns]) begin
                    nxt[ns]   = cand;
                    m_dec[ns] = 1'(s % 2);
                end
            end
        end
        mn = nxt[0];
        for (int i = 1; i < 8; i++) if (nxt[i] < mn) mn = nxt[i];
        if (mn >= HALF) begin
            for (int i = 0; i < 8; i++) nxt[i] -= HALF;
        end
        m_bs = 0;
        for (int i = 0; i < 8; i++) begin
            m_pm[i] = nxt[i];
            if (nxt[i] < nxt[m_bs]) m_bs = i;
        end
        m_bp    = nxt[m_bs];
        m_valid = 1'b1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_dec_valid"}, 32'(dec_valid), 32'(m_valid));
        check({tag, "_dec_bits"}, 32'(dec_bits), 32'(m_dec));
        check({tag, "_best_state"}, 32'(best_state), 32'(m_bs));
        check({tag, "_best_pm"}, 32'(best_pm), 32'(m_bp));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_pm%0d", tag, i), 32'(dut.pm[i]), 32'(m_pm[i]));
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic clr, input string tag);
        @(negedge clk);
        in_valid = v;
        bm       = b;
        sync_clr = clr;
        @(posedge clk);
        #1;
        model_step(v, b, clr);
        check_all(tag);
    endtask

    task automatic scenario1_checks(input string tag);
        check({tag, "_s1_valid"}, 32'(dec_valid), 32'd1);
        check({tag, "_s1_best_state"}, 32'(best_state), 32'd0);
        check({tag, "_s1_best_pm"}, 32'(best_pm), 32'd0);
        check({tag, "_s1_dec0"}, 32'(dec_bits[0]), 32'd0);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("%s_s1_pm%0d_ge1", tag, i), 32'(dut.pm[i] >= 1), 32'd1);
        end
    endtask

    initial begin
        int         u_seq [7];
        int         rx    [7];
        logic [7:0] hist  [7];
        int         es;
        int         st;
        logic [7:0] rb;

        u_seq = '{1, 0, 1, 1, 0, 0, 0};

        rst_n    = 1'b0;
        sync_clr = 1'b0;
        in_valid = 1'b0;
        bm       = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: single step with distinct codeword distances
        step(1'b1, 8'h94, 1'b0, "sc1");
        scenario1_checks("sc1");
        step(1'b0, 8'h00, 1'b0, "sc1_idle");

        // Scenario 2: constant bm=2 for 64 steps exercises ties and normalization
        step(1'b0, 8'h00, 1'b1, "sc2_clr");
        for (int k = 1; k <= 64; k++) begin
            step(1'b1, 8'hAA, 1'b0, $sformatf("sc2_k%0d", k));
            check($sformatf("sc2_dec_zero_k%0d", k), 32'(dec_bits), 32'd0);
            if (k == 3) begin
                for (int i = 0; i < 8; i++) begin
                    check($sformatf("sc2_all6_pm%0d", i), 32'(dut.pm[i]), 32'd6);
                end
            end
            if (k == 63) check("sc2_best126", 32'(best_pm), 32'd126);
            if (k == 64) check("sc2_best_norm0", 32'(best_pm), 32'd0);
        end

        // Scenarios 3 and 4: clean and single-error encoded streams, then traceback
        es = 0;
        for (int t = 0; t < 7; t++) begin
            rx[t] = encode(es, u_seq[t]);
            es    = u_seq[t] * 4 + es / 2;
        end
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b0, 8'h00, 1'b1, $sformatf("sc3_clr_p%0d", pass));
            for (int t = 0; t < 7; t++) begin
                st = rx[t];
                if (pass == 1 && t == 2) st = st ^ 2;
                step(1'b1, bm_for(st), 1'b0, $sformatf("sc3_p%0d_t%0d", pass, t));
                hist[t] = dec_bits;
            end
            check($sformatf("sc3_p%0d_best_state", pass), 32'(best_state), 32'd0);
            check($sformatf("sc3_p%0d_best_pm", pass), 32'(best_pm), 32'(pass));
            st = 0;
            for (int t = 6; t >= 0; t--) begin
                check($sformatf("sc3_p%0d_tb_u%0d", pass, t), 32'((st >> 2) & 1), 32'(u_seq[t]));
                st = ((st & 3) << 1) | int'(hist[t][st]);
            end
        end

        // Scenario 5: sync_clr together with in_valid drops the sample
        for (int k = 0; k < 5; k++) begin
            rb = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                  2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            step(1'b1, rb, 1'b0, $sformatf("sc5_pre%0d", k));
        end
        step(1'b1, 8'h55, 1'b1, "sc5_clr");
        check("sc5_dv0", 32'(dec_valid), 32'd0);
        check("sc5_pm0", 32'(dut.pm[0]), 32'd0);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("sc5_pm%0d_init", i), 32'(dut.pm[i]), 32'(INIT_PM));
        end
        step(1'b1, 8'h94, 1'b0, "sc5_after");
        scenario1_checks("sc5_after");

        // Random stream with idle cycles and occasional clears
        for (int k = 0; k < 300; k++) begin
            rb = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                  2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            step(1'($urandom_range(0, 3) != 0), rb, 1'($urandom_range(0, 59) == 0),
                 $sformatf("rnd%0d", k));
        end

        // Scenario 6: asynchronous reset pulse mid-stream
        step(1'b1, 8'h1B, 1'b0, "sc6_pre0");
        step(1'b1, 8'h6C, 1'b0, "sc6_pre1");
        @(negedge clk);
        in_valid = 1'b1;
        bm       = 8'h27;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("sc6_arst");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h94, 1'b0, "sc6_after");
        scenario1_checks("sc6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
